ccw_gen_frm: RTL and testbench
==============================

# ccw_gen_frm

Parametrised control-code-word frame generator; successor to the fixed 8-bit CCW generator in the telemetry path. On a rising edge of `pre_tm` it emits one frame to the downstream serialiser: a length header word followed by N payload words. Payload follows a runtime-selected pattern: increment, decrement, constant or LFSR. Transfer is flow-controlled by a valid/read handshake, and the whole block runs on a single clock.

## Interface
- `DW`, 8: data word width (≥ `LEN_W`, ≥ 4).
- `LEN_W`, 6: width of payload length field.
- `DEF_SEED`, 8'hAB: payload seed used when `seed_ld` never asserted since reset.
- `LFSR_POLY`, 8'hB8: Galois right-shift LFSR tap mask (`DW` bits).
- `CRC_POLY`, 8'h07: CRC tap mask, used only with the CRC trailer (`DW` bits).
- `clk`  in  1  system clock.
- `n_rst`  in  1  asynchronous active-low reset.
- `pre_tm`  in  1  frame trigger; a rising edge starts a frame.
- `len_cfg`  in  `LEN_W`  payload word count, latched at start.
- `mode`  in  2  pattern select, latched at start: 0 inc, 1 dec, 2 const, 3 LFSR.
- `seed`  in  `DW`  new seed value.
- `seed_ld`  in  1  load `seed` into the seed register (ignored while busy).
- `ccw_d`  out  `DW`  current word.
- `ccw_vld`  out  1  `ccw_d` valid.
- `ccw_rd`  in  1  consumer takes word; transfer = `ccw_vld & ccw_rd`.
- `ccw_tx_rdy`  out  1  frame in progress (HDR, PL or CRC state).
- `ccw_done`  out  1  one-cycle pulse after last word of frame transferred.

## Operation
- Start detect: `pre_tm_d` register; `start = pre_tm & ~pre_tm_d`.
- FSM states: IDLE, HDR, PL, CRC (CRC only with macro).
- On `start`, from any state, the FSM goes to HDR.
  - Latch `len_cfg` into `len_q` and `mode` into `mode_q`.
  - Set `remain = len_q`.
  - Set `pat = seed_reg`; in mode 3, a zero seed is replaced with 1.
  - Clear CRC to 0.
- HDR: `ccw_d = {0, len_q}` (zero-extended). On transfer:
  - go to PL if `len_q != 0`;
  - otherwise go to CRC or IDLE.
- PL: `ccw_d = pat`. On transfer:
  - `remain` decrements;
  - `pat` advances: inc +1 mod 2^DW; dec −1 mod 2^DW; const unchanged; LFSR `pat = (pat>>1) ^ (pat[0] ? LFSR_POLY : 0)`.
  - When the transferring word has `remain == 1`, go to CRC or IDLE.
- CRC: `ccw_d` = CRC over header and all payload words, MSB-first, whole word per cycle, init 0. On transfer, go to IDLE.
- IDLE: `ccw_d = 0`, `ccw_vld = 0`.
- `ccw_vld = 1` in HDR, PL and CRC.
- Words are stable while `ccw_vld & ~ccw_rd`; the block never drops or repeats a word.
- `seed_ld` takes effect only in IDLE. A load in the same cycle as `start` is ignored for the frame being started.

## Timing
- Reset values:
  - FSM IDLE; `ccw_d` 0; `ccw_vld`, `ccw_tx_rdy`, `ccw_done` 0;
  - `seed_reg = DEF_SEED`; `pre_tm_d = 0`; `len_q`, `mode_q`, `remain`, CRC cleared.
- All outputs are registered or decoded from registered state. No combinational path from `ccw_rd` to `ccw_d` or `ccw_vld`.
- `pre_tm` rises in cycle T, so the header is valid in T+1.
- Each word advances one cycle after its transfer. With `ccw_rd` held high, the frame takes `len_q + 1` cycles, or `len_q + 2` with CRC.
- `ccw_done` pulses in the cycle after the final transfer, coincident with IDLE.
- `start` coincident with a transfer: start wins, the in-flight frame is aborted without `ccw_done`, and the header of the new frame is valid next cycle.
- `pre_tm` held high starts exactly one frame.
- Assertion of `n_rst` mid-frame forces the reset values immediately.

## Configuration
- `CCW_GEN_CRC_EN` defined: CRC state is compiled in, and every frame ends with one CRC trailer word (`len_q + 2` words total).
- Not defined: no CRC logic or state. Frames are `len_q + 1` words, and `CRC_POLY` is unused.

## Test plan
- Reset, then `pre_tm` edge with defaults (len 62, mode 0), `ccw_rd` = 1 → header 0x3E, then payload 0xAB..0xE8, then `ccw_done` pulse and `ccw_vld` low.
- Seed load 0xF0, len 20, mode 0 → payload 0xF0..0xFF then 0x00..0x03 (wrap-around).
- Mode 3, seed 0xAB, len 3 → 0x03, 0xAB, 0xED, then the next LFSR value. With seed 0x00, the first payload word is 0x01.
- `ccw_rd` toggled randomly, mode 1, seed 0x05, len 8 → received sequence 0x08, 0x05, 0x04, …, 0xFE, with no gaps or repeats and `ccw_d` stable during stalls.
- Second `pre_tm` edge mid-payload, and separately len 0 → frame restarts with header next cycle and no `ccw_done` for the aborted frame; len 0 emits header 0x00 only, then `ccw_done`.
- With `CCW_GEN_CRC_EN`, len 1, seed 0xAB, mode 0 → 0x01, 0xAB, 0x4D.

Source files
------------

// File: rtl/ccw_gen_frm.sv
// ccw_gen_frm -- control-code-word frame generator.
//
// A rising edge on pre_tm starts one frame: a length header word, then
// len_cfg payload words. The payload pattern is chosen by mode:
// 0 increment, 1 decrement, 2 constant, 3 Galois LFSR.
// Words are handed over on a valid/read handshake, where a transfer is
// ccw_vld & ccw_rd.
//
// Optional feature: define CCW_GEN_CRC_EN to append one CRC trailer word to
// every frame. The CRC is computed over the header and payload, MSB-first,
// one whole word per step, starting from 0.
//
// Ports:
//   clk         system clock
//   n_rst       asynchronous active-low reset
//   pre_tm      frame trigger (rising edge starts a frame)
//   len_cfg     payload word count, latched at start
//   mode        pattern select, latched at start
//   seed        new seed value
//   seed_ld     load seed into the seed register (only while idle)
//   ccw_d       current word (0 while idle)
//   ccw_vld     ccw_d valid
//   ccw_rd      consumer takes the word
//   ccw_tx_rdy  frame in progress
//   ccw_done    one-cycle pulse after the last word of a frame transferred
module ccw_gen_frm #(
   parameter int              DW        = 8,
   parameter int              LEN_W     = 6,
   parameter logic [DW-1:0]   DEF_SEED  = 8'hAB,
   parameter logic [DW-1:0]   LFSR_POLY = 8'hB8,
   parameter logic [DW-1:0]   CRC_POLY  = 8'h07
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             pre_tm,
   input  logic [LEN_W-1:0] len_cfg,
   input  logic [1:0]       mode,
   input  logic [DW-1:0]    seed,
   input  logic             seed_ld,
   output logic [DW-1:0]    ccw_d,
   output logic             ccw_vld,
   input  logic             ccw_rd,
   output logic             ccw_tx_rdy,
   output logic             ccw_done
);

   typedef enum logic [1:0] {
`ifdef CCW_GEN_CRC_EN
      S_CRC  = 2'd3,
`endif
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_PL   = 2'd2
   } state_t;

   state_t           state;
   logic             pre_tm_d;
   logic [LEN_W-1:0] len_q;
   logic [1:0]       mode_q;
   logic [LEN_W-1:0] remain;
   logic [DW-1:0]    pat;
   logic [DW-1:0]    seed_reg;

   logic             start;
   logic             xfer;
   logic             last_word;
   logic [DW-1:0]    pat_adv;
   logic [DW-1:0]    start_pat;

   assign start = pre_tm & ~pre_tm_d;
   assign xfer  = ccw_vld & ccw_rd;

   // The word being transferred is the last header/payload word of the frame.
   assign last_word = ((state == S_HDR) && (len_q == '0)) ||
                      ((state == S_PL) && (remain == LEN_W'(1)));

   // An all-zero LFSR state would lock up, so a zero seed becomes 1 in mode 3.
   assign start_pat = ((mode == 2'd3) && (seed_reg == '0)) ? DW'(1) : seed_reg;

   always_comb begin
      pat_adv = pat;
      case (mode_q)
         2'd0:    pat_adv = pat + DW'(1);
         2'd1:    pat_adv = pat - DW'(1);
         2'd2:    pat_adv = pat;
         default: pat_adv = (pat >> 1) ^ (pat[0] ? LFSR_POLY : '0);
      endcase
   end

`ifdef CCW_GEN_CRC_EN
   logic [DW-1:0] crc;
   logic [DW-1:0] crc_after;

   function automatic logic [DW-1:0] crc_step(input logic [DW-1:0] c_in,
                                               input logic [DW-1:0] w);
      logic [DW-1:0] c;
      c = c_in ^ w;
      for (int i = 0; i < DW; i++)
         c = c[DW-1] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      return c;
   endfunction

   // ccw_d is registered and always holds the word now on offer, so the
   // CRC can be folded in straight from it on transfer.
   assign crc_after = crc_step(crc, ccw_d);
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= S_IDLE;
         pre_tm_d   <= 1'b0;
         len_q      <= '0;
         mode_q     <= 2'd0;
         remain     <= '0;
         pat        <= '0;
         seed_reg   <= DEF_SEED;
         ccw_d      <= '0;
         ccw_vld    <= 1'b0;
         ccw_tx_rdy <= 1'b0;
         ccw_done   <= 1'b0;
`ifdef CCW_GEN_CRC_EN
         crc        <= '0;
`endif
      end else begin
         pre_tm_d <= pre_tm;
         ccw_done <= 1'b0;

         // Loads while idle always land in the register; a load in the start
         // cycle is not seen by that frame because start_pat uses the old value.
         if ((state == S_IDLE) && seed_ld)
            seed_reg <= seed;

         if (start) begin
            // Start wins over everything, including an in-flight transfer.
            state      <= S_HDR;
            len_q      <= len_cfg;
            mode_q     <= mode;
            remain     <= len_cfg;
            pat        <= start_pat;
            ccw_d      <= DW'(len_cfg);
            ccw_vld    <= 1'b1;
            ccw_tx_rdy <= 1'b1;
`ifdef CCW_GEN_CRC_EN
            crc        <= '0;
`endif
         end else if (xfer) begin
            if (state == S_PL) begin
               remain <= remain - LEN_W'(1);
               pat    <= pat_adv;
            end
`ifdef CCW_GEN_CRC_EN
            if (state != S_CRC)
               crc <= crc_after;
            if (state == S_CRC) begin
               state      <= S_IDLE;
               ccw_d      <= '0;
               ccw_vld    <= 1'b0;
               ccw_tx_rdy <= 1'b0;
               ccw_done   <= 1'b1;
            end else if (last_word) begin
               state <= S_CRC;
               ccw_d <= crc_after;
            end
`else
            if (last_word) begin
               state      <= S_IDLE;
               ccw_d      <= '0;
               ccw_vld    <= 1'b0;
               ccw_tx_rdy <= 1'b0;
               ccw_done   <= 1'b1;
            end
`endif
            else begin
               // From HDR the first payload word is pat itself; within PL the
               // next word is the advanced pattern.
               state <= S_PL;
               ccw_d <= (state == S_HDR) ? pat : pat_adv;
            end
         end
      end
   end

endmodule

// File: tb/tb_ccw_gen_frm.sv
// Testbench for ccw_gen_frm: scenario tasks push expected words into a
// scoreboard queue and pop/compare them as the DUT transfers words.
module tb_ccw_gen_frm;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       pre_tm = 1'b0;
   logic [5:0] len_cfg = '0;
   logic [1:0] mode = 2'd0;
   logic [7:0] seed = '0;
   logic       seed_ld = 1'b0;
   logic [7:0] ccw_d;
   logic       ccw_vld;
   logic       ccw_rd = 1'b1;
   logic       ccw_tx_rdy;
   logic       ccw_done;

   int         n_vec = 0;
   int         n_bad = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   ccw_gen_frm dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .pre_tm     (pre_tm),
      .len_cfg    (len_cfg),
      .mode       (mode),
      .seed       (seed),
      .seed_ld    (seed_ld),
      .ccw_d      (ccw_d),
      .ccw_vld    (ccw_vld),
      .ccw_rd     (ccw_rd),
      .ccw_tx_rdy (ccw_tx_rdy),
      .ccw_done   (ccw_done)
   );

   // ---------------- reference model ----------------
   function automatic logic [7:0] crc8(input logic [7:0] c_in, input logic [7:0] w);
      logic [7:0] c;
      c = c_in ^ w;
      for (int i = 0; i < 8; i++)
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      return c;
   endfunction

   function automatic logic [7:0] pat_next(input logic [1:0] m, input logic [7:0] p);
      case (m)
         2'd0:    return p + 8'd1;
         2'd1:    return p - 8'd1;
         2'd2:    return p;
         default: return {1'b0, p[7:1]} ^ (p[0] ? 8'hB8 : 8'h00);
      endcase
   endfunction

   // CRC over the queue entries from index 'from' to the end.
   function automatic logic [7:0] crc_tail(input int from);
      logic [7:0] c;
      c = 8'h00;
      for (int i = from; i < exp_q.size(); i++)
         c = crc8(c, exp_q[i]);
      return c;
   endfunction

   task automatic push_frame(input int len, input logic [1:0] m, input logic [7:0] s);
      logic [7:0] p;
      int         first;
      first = exp_q.size();
      exp_q.push_back(8'(len));
      p = ((m == 2'd3) && (s == 8'h00)) ? 8'h01 : s;
      for (int i = 0; i < len; i++) begin
         exp_q.push_back(p);
         p = pat_next(m, p);
      end
`ifdef CCW_GEN_CRC_EN
      exp_q.push_back(crc_tail(first));
`else
      if (first < 0) exp_q.delete();
`endif
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic load_seed(input logic [7:0] s);
      @(posedge clk); #1;
      seed = s; seed_ld = 1'b1;
      @(posedge clk); #1;
      seed_ld = 1'b0;
   endtask

   // Returns just after the start edge; header is visible at the next negedge.
   task automatic start_pulse();
      @(posedge clk); #1;
      pre_tm = 1'b1;
      @(posedge clk); #1;
      pre_tm = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      n_rst = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++; if (ccw_d !== 8'h00) begin n_bad++; $display("FAIL reset_d: got %h want 00", ccw_d); end
      n_vec++; if (ccw_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", ccw_vld); end
      n_vec++; if (ccw_tx_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b want 0", ccw_tx_rdy); end
      n_vec++; if (ccw_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", ccw_done); end
      @(posedge clk); #1;
      n_rst = 1'b1;
      @(posedge clk); #1;
   endtask

   // Default seed, len 62, mode 0, pre_tm held high for the whole frame.
   task automatic test_default();
      logic [7:0] e;
      int gaps = 0;
      len_cfg = 6'd62; mode = 2'd0; ccw_rd = 1'b1;
      exp_q.delete();
      push_frame(62, 2'd0, 8'hAB);
      @(posedge clk); #1;
      pre_tm = 1'b1;
      @(posedge clk);
      for (int b = 0; b < 200 && exp_q.size() > 0; b++) begin
         @(negedge clk);
         if (ccw_vld && ccw_rd) begin
            e = exp_q.pop_front();
            n_vec++; if (ccw_d !== e) begin n_bad++; $display("FAIL default_word: got %h want %h", ccw_d, e); end
            n_vec++; if (ccw_tx_rdy !== 1'b1) begin n_bad++; $display("FAIL default_rdy: got %b want 1", ccw_tx_rdy); end
         end else gaps++;
      end
      n_vec++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL default_timeout: %0d words left want 0", exp_q.size()); end
      n_vec++; if (gaps != 0) begin n_bad++; $display("FAIL default_gaps: got %0d want 0", gaps); end
      @(negedge clk);
      n_vec++; if (ccw_done !== 1'b1) begin n_bad++; $display("FAIL default_done: got %b want 1", ccw_done); end
      n_vec++; if (ccw_vld !== 1'b0) begin n_bad++; $display("FAIL default_idle_vld: got %b want 0", ccw_vld); end
      repeat (3) @(negedge clk);
      n_vec++; if (ccw_vld !== 1'b0) begin n_bad++; $display("FAIL default_held_restart: vld %b want 0", ccw_vld); end
      @(posedge clk); #1;
      pre_tm = 1'b0;
   endtask

   task automatic test_seed_wrap();
      logic [7:0] e;
      load_seed(8'hF0);
      len_cfg = 6'd20; mode = 2'd0;
      exp_q.delete();
      push_frame(20, 2'd0, 8'hF0);
      start_pulse();
      for (int b = 0; b < 100 && exp_q.size() > 0; b++) begin
         @(negedge clk);
         if (ccw_vld && ccw_rd) begin
            e = exp_q.pop_front();
            n_vec++; if (ccw_d !== e) begin n_bad++; $display("FAIL wrap_word: got %h want %h", ccw_d, e); end
         end
      end
      n_vec++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL wrap_timeout: %0d words left want 0", exp_q.size()); end
      @(negedge clk);
      n_vec++; if (ccw_done !== 1'b1) begin n_bad++; $display("FAIL wrap_done: got %b want 1", ccw_done); end
   endtask

   task automatic test_lfsr();
      logic [7:0] e;
      for (int k = 0; k < 2; k++) begin
         exp_q.delete();
         if (k == 0) begin
            load_seed(8'hAB); len_cfg = 6'd3;
            exp_q.push_back(8'h03); exp_q.push_back(8'hAB);
            exp_q.push_back(8'hED); exp_q.push_back(8'hCE);
         end else begin
            load_seed(8'h00); len_cfg = 6'd1;
            exp_q.push_back(8'h01); exp_q.push_back(8'h01);
         end
`ifdef CCW_GEN_CRC_EN
         exp_q.push_back(crc_tail(0));
`endif
         mode = 2'd3;
         start_pulse();
         for (int b = 0; b < 50 && exp_q.size() > 0; b++) begin
            @(negedge clk);
            if (ccw_vld && ccw_rd) begin
               e = exp_q.pop_front();
               n_vec++; if (ccw_d !== e) begin n_bad++; $display("FAIL lfsr%0d_word: got %h want %h", k, ccw_d, e); end
            end
         end
         n_vec++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL lfsr%0d_timeout: %0d words left want 0", k, exp_q.size()); end
         @(negedge clk);
         n_vec++; if (ccw_done !== 1'b1) begin n_bad++; $display("FAIL lfsr%0d_done: got %b want 1", k, ccw_done); end
      end
   endtask

   task automatic test_random_rd();
      logic [7:0] e;
      logic [7:0] stall_d = '0;
      logic       stalled = 1'b0;
      load_seed(8'h05);
      len_cfg = 6'd8; mode = 2'd1;
      exp_q.delete();
      push_frame(8, 2'd1, 8'h05);
      ccw_rd = 1'($urandom_range(0, 1));
      start_pulse();
      for (int b = 0; b < 400 && exp_q.size() > 0; b++) begin
         @(negedge clk);
         if (stalled) begin
            n_vec++;
            if (ccw_d !== stall_d || ccw_vld !== 1'b1) begin
               n_bad++; $display("FAIL rand_stall: got %h/%b want %h/1", ccw_d, ccw_vld, stall_d);
            end
         end
         stalled = ccw_vld && !ccw_rd;
         stall_d = ccw_d;
         if (ccw_vld && ccw_rd) begin
            e = exp_q.pop_front();
            n_vec++; if (ccw_d !== e) begin n_bad++; $display("FAIL rand_word: got %h want %h", ccw_d, e); end
         end
         if (exp_q.size() > 0) begin
            @(posedge clk); #1;
            ccw_rd = 1'($urandom_range(0, 1));
         end
      end
      n_vec++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rand_timeout: %0d words left want 0", exp_q.size()); end
      @(negedge clk);
      n_vec++; if (ccw_done !== 1'b1) begin n_bad++; $display("FAIL rand_done: got %b want 1", ccw_done); end
      @(posedge clk); #1;
      ccw_rd = 1'b1;
   endtask

   // Restart mid-payload, coincident with a transfer.
   task automatic test_abort();
      logic [7:0] e;
      int popped = 0;
      bit fired = 0;
      load_seed(8'h10);
      len_cfg = 6'd10; mode = 2'd0; ccw_rd = 1'b1;
      exp_q.delete();
      exp_q.push_back(8'h0A); exp_q.push_back(8'h10); exp_q.push_back(8'h11);
      exp_q.push_back(8'h12); exp_q.push_back(8'h13);
      push_frame(2, 2'd0, 8'h10);
      start_pulse();
      for (int b = 0; b < 100 && exp_q.size() > 0; b++) begin
         @(negedge clk);
         n_vec++; if (ccw_done !== 1'b0) begin n_bad++; $display("FAIL abort_early_done: got %b want 0", ccw_done); end
         if (ccw_vld && ccw_rd) begin
            e = exp_q.pop_front();
            popped++;
            n_vec++; if (ccw_d !== e) begin n_bad++; $display("FAIL abort_word: got %h want %h", ccw_d, e); end
         end
         if (popped == 4 && !fired) begin
            @(posedge clk); #1;
            len_cfg = 6'd2; pre_tm = 1'b1; fired = 1;
         end
      end
      n_vec++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL abort_timeout: %0d words left want 0", exp_q.size()); end
      @(negedge clk);
      n_vec++; if (ccw_done !== 1'b1) begin n_bad++; $display("FAIL abort_done: got %b want 1", ccw_done); end
      @(posedge clk); #1;
      pre_tm = 1'b0;
   endtask

   task automatic test_len0();
      logic [7:0] e;
      len_cfg = 6'd0; mode = 2'd0;
      exp_q.delete();
      push_frame(0, 2'd0, 8'h10);
      start_pulse();
      for (int b = 0; b < 20 && exp_q.size() > 0; b++) begin
         @(negedge clk);
         if (ccw_vld && ccw_rd) begin
            e = exp_q.pop_front();
            n_vec++; if (ccw_d !== e) begin n_bad++; $display("FAIL len0_word: got %h want %h", ccw_d, e); end
         end
      end
      n_vec++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL len0_timeout: %0d words left want 0", exp_q.size()); end
      @(negedge clk);
      n_vec++; if (ccw_done !== 1'b1) begin n_bad++; $display("FAIL len0_done: got %b want 1", ccw_done); end
      n_vec++; if (ccw_vld !== 1'b0) begin n_bad++; $display("FAIL len0_vld: got %b want 0", ccw_vld); end
   endtask

   // Reset mid-frame, then a short frame that relies on the seed returning to 0xAB.
   task automatic test_reset_crc();
      logic [7:0] e;
      len_cfg = 6'd10; mode = 2'd0;
      start_pulse();
      repeat (3) @(negedge clk);
      #2 n_rst = 1'b0;
      #1;
      n_vec++; if (ccw_vld !== 1'b0) begin n_bad++; $display("FAIL midrst_vld: got %b want 0", ccw_vld); end
      n_vec++; if (ccw_d !== 8'h00) begin n_bad++; $display("FAIL midrst_d: got %h want 00", ccw_d); end
      n_vec++; if (ccw_tx_rdy !== 1'b0) begin n_bad++; $display("FAIL midrst_rdy: got %b want 0", ccw_tx_rdy); end
      @(posedge clk); #1;
      n_rst = 1'b1;
      len_cfg = 6'd1; mode = 2'd0;
      exp_q.delete();
      exp_q.push_back(8'h01); exp_q.push_back(8'hAB);
`ifdef CCW_GEN_CRC_EN
      exp_q.push_back(8'h4D);
`endif
      start_pulse();
      for (int b = 0; b < 20 && exp_q.size() > 0; b++) begin
         @(negedge clk);
         if (ccw_vld && ccw_rd) begin
            e = exp_q.pop_front();
            n_vec++; if (ccw_d !== e) begin n_bad++; $display("FAIL postrst_word: got %h want %h", ccw_d, e); end
         end
      end
      n_vec++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL postrst_timeout: %0d words left want 0", exp_q.size()); end
      @(negedge clk);
      n_vec++; if (ccw_done !== 1'b1) begin n_bad++; $display("FAIL postrst_done: got %b want 1", ccw_done); end
   endtask

   initial begin
      test_reset();
      test_default();
      test_seed_wrap();
      test_lfsr();
      test_random_rd();
      test_abort();
      test_len0();
      test_reset_crc();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule
